// File: rtl/tracking_frame_arbiter.sv
// Purpose : shares one tracking engine between two camera pixel sources, one whole frame per grant, round-robin.
// Latency : pixel path is combinational (zero cycles); result strobe one cycle after capture.
// Backpr. : trk_full drops the granted source's ready; the non-granted source always sees ready=0.
//
// Ports:
//   clock_50, reset (async, active-low)
//   src0_valid/src0_data/src0_ready, src1_valid/src1_data/src1_ready : 24-bit BGR pixel streams
//   trk_wr_en/trk_din/trk_full : write side of the engine input FIFO
//   trk_valid/trk_center_x/trk_center_y/trk_width/trk_height : engine result
//   res_valid/res_src/res_err/res_center_x/res_center_y/res_width/res_height : tagged result
//   grant : current/last granted source, busy : high outside IDLE
//
// Optional build macro TRK_ARB_TIMEOUT_EN: bounds WAIT_RESULT to TIMEOUT_CYCLES cycles and
// reports an aborted frame with res_err=1 and zeroed fields. Undefined: waits forever, res_err=0.
module tracking_frame_arbiter #(
  parameter int WIDTH          = 720,
  parameter int HEIGHT         = 540,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        src0_valid,
  input  logic [23:0] src0_data,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [23:0] src1_data,
  output logic        src1_ready,
  output logic        trk_wr_en,
  output logic [23:0] trk_din,
  input  logic        trk_full,
  input  logic        trk_valid,
  input  logic [11:0] trk_center_x,
  input  logic [11:0] trk_center_y,
  input  logic [11:0] trk_width,
  input  logic [11:0] trk_height,
  output logic        res_valid,
  output logic        res_src,
  output logic        res_err,
  output logic [11:0] res_center_x,
  output logic [11:0] res_center_y,
  output logic [11:0] res_width,
  output logic [11:0] res_height,
  output logic        grant,
  output logic        busy
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]    r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic          r_pend;
  logic [CW-1:0] r_pix_cnt;
  logic [23:0]   r_din;
  logic [11:0]   r_cx, r_cy, r_w, r_h;

  logic          w_streaming;
  logic          w_src_vld;
  logic [23:0]   w_src_dat;
  logic          w_xfer;
  logic          w_last;
  logic          w_timeout;

  assign w_streaming = (r_state == S_STREAM);
  assign w_src_vld   = r_grant ? src1_valid : src0_valid;
  assign w_src_dat   = r_grant ? src1_data  : src0_data;
  assign w_xfer      = w_streaming & w_src_vld & ~trk_full;
  assign w_last      = w_xfer & (r_pix_cnt == LAST_PIX);

  assign src0_ready   = w_streaming & ~r_grant & ~trk_full;
  assign src1_ready   = w_streaming &  r_grant & ~trk_full;
  assign trk_wr_en    = w_xfer;
  // Outside a transfer the FIFO data bus keeps the last written pixel.
  assign trk_din      = w_xfer ? w_src_dat : r_din;
  assign res_valid    = (r_state == S_REPORT);
  assign res_src      = r_grant;
  assign res_center_x = r_cx;
  assign res_center_y = r_cy;
  assign res_width    = r_w;
  assign res_height   = r_h;
  assign grant        = r_grant;
  assign busy         = (r_state != S_IDLE);

`ifdef TRK_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  // Counter is 0 on the first WAIT_RESULT cycle, so REPORT lands exactly TIMEOUT_CYCLES later.
  assign w_timeout = (r_state == S_WAIT) & ~trk_valid & (r_to_cnt == TO_LAST);
  assign res_err   = r_err;

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + TW'(1);
      else                   r_to_cnt <= '0;
      if (w_timeout)
        r_err <= 1'b1;
      else if (trk_valid && (r_state == S_STREAM || r_state == S_WAIT))
        r_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign res_err   = 1'b0;
`endif

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_pend       <= 1'b0;
      r_pix_cnt    <= '0;
      r_din        <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_w          <= '0;
      r_h          <= '0;
    end else begin
      if (w_xfer) r_din <= w_src_dat;
      case (r_state)
        S_IDLE: begin
          if (src0_valid | src1_valid) begin
            r_grant <= (src0_valid & src1_valid) ? ~r_last_grant : src1_valid;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          // Engine may still be finishing the previous frame; keep its result pending.
          if (trk_valid) begin
            r_cx   <= trk_center_x;
            r_cy   <= trk_center_y;
            r_w    <= trk_width;
            r_h    <= trk_height;
            r_pend <= 1'b1;
          end
          if (w_xfer) begin
            if (w_last) begin
              r_pix_cnt    <= '0;
              r_last_grant <= r_grant;
              // A result arriving with the last pixel counts as already pending.
              r_state      <= (r_pend | trk_valid) ? S_REPORT : S_WAIT;
            end else begin
              r_pix_cnt <= r_pix_cnt + CW'(1);
            end
          end
        end
        S_WAIT: begin
          if (trk_valid) begin
            r_cx    <= trk_center_x;
            r_cy    <= trk_center_y;
            r_w     <= trk_width;
            r_h     <= trk_height;
            r_state <= S_REPORT;
          end else if (w_timeout) begin
            r_cx    <= '0;
            r_cy    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_state <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_pend  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tracking_frame_arbiter.sv
// Bench for tracking_frame_arbiter with 4x2 frames: directed phases, pixel and result scoreboards.
module tb_tracking_frame_arbiter;

  localparam int NPIX = 8;

  logic        clock_50 = 1'b0;
  logic        reset = 1'b0;
  logic        src0_valid = 1'b0;
  logic [23:0] src0_data = 24'h000001;
  logic        src1_valid = 1'b0;
  logic [23:0] src1_data = 24'h100001;
  logic        trk_full = 1'b0;
  logic        trk_valid = 1'b0;
  logic [11:0] trk_center_x = '0, trk_center_y = '0, trk_width = '0, trk_height = '0;
  logic        src0_ready, src1_ready, trk_wr_en;
  logic [23:0] trk_din;
  logic        res_valid, res_src, res_err, grant, busy;
  logic [11:0] res_center_x, res_center_y, res_width, res_height;

  always #5 clock_50 = ~clock_50;

  tracking_frame_arbiter #(.WIDTH(4), .HEIGHT(2), .TIMEOUT_CYCLES(16)) dut (
    .clock_50(clock_50), .reset(reset),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
    .trk_wr_en(trk_wr_en), .trk_din(trk_din), .trk_full(trk_full),
    .trk_valid(trk_valid), .trk_center_x(trk_center_x), .trk_center_y(trk_center_y),
    .trk_width(trk_width), .trk_height(trk_height),
    .res_valid(res_valid), .res_src(res_src), .res_err(res_err),
    .res_center_x(res_center_x), .res_center_y(res_center_y),
    .res_width(res_width), .res_height(res_height),
    .grant(grant), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int n_xfer = 0;
  int n_res = 0;
  logic [23:0] pix_q[$];
  logic [49:0] res_q[$];
  logic [23:0] c0 = '0, c1 = '0;
  logic        a0, a1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ctl"}, 64'({src0_ready, src1_ready, trk_wr_en, res_valid, res_src, res_err, grant}), 64'(0));
    chk({tag, "_din"}, 64'(trk_din), 64'(0));
    chk({tag, "_fields"}, 64'({res_center_x, res_center_y, res_width, res_height}), 64'(0));
  endtask

  task automatic push_frame(input logic [23:0] first);
    for (int i = 0; i < NPIX; i++) pix_q.push_back(first + 24'(i));
  endtask

  task automatic push_res(input logic s, input logic e, input logic [11:0] x, input logic [11:0] y,
                          input logic [11:0] w, input logic [11:0] h);
    res_q.push_back({s, e, x, y, w, h});
  endtask

  task automatic reply(input logic [11:0] x, input logic [11:0] y, input logic [11:0] w, input logic [11:0] h);
    trk_center_x = x; trk_center_y = y; trk_width = w; trk_height = h;
    trk_valid = 1'b1;
    @(posedge clock_50); #1;
    trk_valid = 1'b0;
  endtask

  task automatic wait_xfer(input int target);
    int k = 0;
    do begin @(posedge clock_50); #2; k++; end while (n_xfer < target && k < 200);
    chk("xfer_count", 64'(n_xfer), 64'(target));
  endtask

  task automatic wait_res(input int target);
    int k = 0;
    do begin @(posedge clock_50); #2; k++; end while (n_res < target && k < 200);
    chk("result_count", 64'(n_res), 64'(target));
  endtask

  // Source model: each source walks its own data sequence, advancing only on accepted pixels.
  always @(negedge clock_50) begin
    a0 = src0_valid & src0_ready;
    a1 = src1_valid & src1_ready;
    if (!reset) begin
      c0 = '0; c1 = '0;
      src0_data = 24'h000001; src1_data = 24'h100001;
    end else begin
      @(posedge clock_50); #1;
      if (a0) begin c0 = c0 + 24'd1; src0_data = 24'h000001 + c0; end
      if (a1) begin c1 = c1 + 24'd1; src1_data = 24'h100001 + c1; end
    end
  end

  // Output monitor: pixel and result scoreboards.
  always @(negedge clock_50) begin
    if (reset) begin
      if (trk_wr_en) begin
        n_xfer++;
        chk("wr_en_while_full", 64'(trk_full), 64'(0));
        chk("nongranted_ready", 64'(grant ? src0_ready : src1_ready), 64'(0));
        chk("pixel_expected", 64'(pix_q.size() != 0), 64'(1));
        if (pix_q.size() != 0) chk("trk_din", 64'(trk_din), 64'(pix_q.pop_front()));
      end
      if (res_valid) begin
        n_res++;
        chk("result_expected", 64'(res_q.size() != 0), 64'(1));
        if (res_q.size() != 0)
          chk("result", 64'({res_src, res_err, res_center_x, res_center_y, res_width, res_height}),
              64'(res_q.pop_front()));
      end
    end
  end

  initial begin
    int bx, br;
    logic ok;

    // Reset state, held and released.
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    chk_idle("in_reset");
    @(posedge clock_50); #1 reset = 1'b1;
    @(negedge clock_50);
    chk_idle("after_reset");

    // Asynchronous reset in the middle of a frame.
    bx = n_xfer;
    push_frame(24'h000001);
    src0_valid = 1'b1;
    wait_xfer(bx + 3);
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    src0_valid = 1'b0;
    #1 chk_idle("async_reset");
    pix_q.delete();
    @(posedge clock_50); @(posedge clock_50); #1 reset = 1'b1;

    // Single source, one full frame, result in WAIT_RESULT.
    bx = n_xfer; br = n_res;
    push_frame(24'h000001);
    src0_valid = 1'b1;
    wait_xfer(bx + 8);
    src0_valid = 1'b0;
    chk("b_busy_wait", 64'(busy), 64'(1));
    push_res(1'b0, 1'b0, 12'd10, 12'd20, 12'd3, 12'd4);
    reply(12'd10, 12'd20, 12'd3, 12'd4);
    @(negedge clock_50) chk("b_res_valid", 64'(res_valid), 64'(1));
    @(negedge clock_50) chk("b_res_pulse", 64'(res_valid), 64'(0));
    chk("b_n_res", 64'(n_res), 64'(br + 1));

    // Both sources continuously valid: round-robin from reset.
    reset = 1'b0;
    @(posedge clock_50); @(posedge clock_50); #1 reset = 1'b1;
    bx = n_xfer; br = n_res;
    push_frame(24'h000001); push_frame(24'h100001); push_frame(24'h000009);
    src0_valid = 1'b1; src1_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      bx += 8;
      wait_xfer(bx);
      chk("c_grant", 64'(grant), 64'(f == 1));
      if (f == 2) begin src0_valid = 1'b0; src1_valid = 1'b0; end
      push_res(f == 1, 1'b0, 12'(100 + f), 12'(200 + f), 12'(30 + f), 12'(40 + f));
      reply(12'(100 + f), 12'(200 + f), 12'(30 + f), 12'(40 + f));
    end
    wait_res(br + 3);

    // trk_full toggling every cycle during the frame.
    bx = n_xfer; br = n_res;
    push_frame(24'h000011);
    src0_valid = 1'b1;
    for (int k = 0; k < 60 && n_xfer < bx + 8; k++) begin
      @(posedge clock_50); #1 trk_full = ~trk_full;
    end
    trk_full = 1'b0;
    src0_valid = 1'b0;
    repeat (3) @(posedge clock_50);
    #2 chk("d_xfers", 64'(n_xfer), 64'(bx + 8));
    chk("d_busy_wait", 64'(busy), 64'(1));
    push_res(1'b0, 1'b0, 12'd5, 12'd6, 12'd7, 12'd8);
    reply(12'd5, 12'd6, 12'd7, 12'd8);
    wait_res(br + 1);

    // Result arrives with the 6th pixel: REPORT directly after the last pixel.
    bx = n_xfer; br = n_res;
    push_frame(24'h000019);
    push_res(1'b0, 1'b0, 12'd7, 12'd8, 12'd9, 12'd10);
    src0_valid = 1'b1;
    wait_xfer(bx + 5);
    reply(12'd7, 12'd8, 12'd9, 12'd10);
    wait_xfer(bx + 8);
    src0_valid = 1'b0;
    chk("e_report_direct", 64'(res_valid), 64'(1));
    @(negedge clock_50); #1 chk("e_n_res", 64'(n_res), 64'(br + 1));

    // No engine reply after a src1 frame.
    bx = n_xfer; br = n_res;
    push_frame(24'h100009);
    src1_valid = 1'b1;
    wait_xfer(bx + 8);
    src1_valid = 1'b0;
    chk("f_grant", 64'(grant), 64'(1));
`ifdef TRK_ARB_TIMEOUT_EN
    push_res(1'b1, 1'b1, 12'd0, 12'd0, 12'd0, 12'd0);
    repeat (15) @(posedge clock_50);
    #2 chk("f_before_timeout", 64'(res_valid), 64'(0));
    @(posedge clock_50);
    #2 chk("f_timeout_report", 64'(res_valid), 64'(1));
    chk("f_timeout_err", 64'(res_err), 64'(1));
`else
    ok = 1'b1;
    repeat (1000) begin
      @(negedge clock_50);
      if (busy !== 1'b1 || res_valid !== 1'b0) ok = 1'b0;
    end
    chk("f_wait_forever", 64'(ok), 64'(1));
    push_res(1'b1, 1'b0, 12'd1, 12'd2, 12'd3, 12'd4);
    reply(12'd1, 12'd2, 12'd3, 12'd4);
`endif
    wait_res(br + 1);

    chk("pix_q_drained", 64'(pix_q.size()), 64'(0));
    chk("res_q_drained", 64'(res_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tracking_frame_arbiter.md
Name: tracking_frame_arbiter

Overview:
- Shares the single `tracking` engine between two pixel sources (camera paths 0 and 1).
- Grants one source for a whole frame of WIDTH*HEIGHT pixels and forwards its pixels into the engine's input FIFO write port.
- After the frame, waits for the engine's result, tags it with the source ID, presents it, then re-arbitrates round-robin.
- Sits between the per-camera pixel streams and `tracking`, in the clock_50 domain.

Parameters:
- WIDTH, 720, pixels per line.
- HEIGHT, 540, lines per frame.
- TIMEOUT_CYCLES, 65536, max clock_50 cycles spent in WAIT_RESULT (only used with the optional feature).

Ports:
- clock_50  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- src0_valid  in  1  source 0 pixel valid.
- src0_data  in  24  source 0 pixel, BGR as read from BMP.
- src0_ready  out  1  source 0 pixel accepted this cycle when valid.
- src1_valid  in  1  source 1 pixel valid.
- src1_data  in  24  source 1 pixel.
- src1_ready  out  1  source 1 ready.
- trk_wr_en  out  1  write strobe to tracking in_wr_en.
- trk_din  out  24  pixel to tracking in_din.
- trk_full  in  1  tracking in_full.
- trk_valid  in  1  tracking result strobe.
- trk_center_x, trk_center_y, trk_width, trk_height  in  12 each  tracking result fields.
- res_valid  out  1  one-cycle result strobe.
- res_src  out  1  source ID of the result.
- res_err  out  1  result aborted by timeout.
- res_center_x, res_center_y, res_width, res_height  out  12 each  latched result.
- grant  out  1  currently/last granted source.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, last_grant=1, pix_cnt=0, pend=0.
  - All outputs 0: ready, trk_wr_en, trk_din, res_* and busy.
  - Reset mid-frame abandons the frame; the engine is reset by its own reset.
- States: IDLE, STREAM, WAIT_RESULT, REPORT.
- IDLE:
  - If exactly one srcN_valid is high: grant=N and go to STREAM.
  - If both are high: grant=~last_grant.
  - No pixel is transferred in the IDLE cycle.
- STREAM:
  - src_ready[grant] = !trk_full. The non-granted ready is 0.
  - Transfer = src_valid[grant] & src_ready[grant].
  - trk_wr_en = transfer. trk_din = src_data[grant]. Both are combinational (zero latency).
  - trk_din holds its last value when there is no transfer.
  - pix_cnt (width clog2(WIDTH*HEIGHT)) increments per transfer.
  - On the transfer with pix_cnt==WIDTH*HEIGHT-1: pix_cnt=0 and last_grant=grant.
    - Then go to REPORT if pend=1, else to WAIT_RESULT.
- trk_valid while in STREAM:
  - Latches the trk_* fields into the res_* registers and sets pend=1.
  - A second trk_valid in STREAM overwrites the latched fields.
- WAIT_RESULT:
  - Ready is 0.
  - On trk_valid: latch fields and go to REPORT.
- REPORT:
  - res_valid=1 for exactly one cycle.
  - res_src=grant, res_err as determined. res_* fields hold until the next latch.
  - pend is cleared; next state is IDLE.
- trk_valid in IDLE or REPORT is ignored.
- trk_full in the same cycle as src_valid: no transfer and no count. The pixel stays offered.
- A source deasserting valid mid-frame keeps the grant; there is no preemption.

Optional Feature:
- Macro TRK_ARB_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in WAIT_RESULT.
  - After TIMEOUT_CYCLES cycles without trk_valid, go to REPORT with res_err=1 and the result fields zeroed.
  - res_err=0 on a normal result.
- Undefined:
  - WAIT_RESULT waits indefinitely.
  - res_err is tied 0 and no counter logic is present.

Test Plan (WIDTH=4, HEIGHT=2, 8-pixel frames):
- Reset then idle: every output 0 and busy=0; assert reset=0 mid-STREAM after 3 pixels -> state IDLE, pix_cnt=0 and outputs 0 immediately (asynchronous).
- Only src0 streams 8 pixels 0x000001..0x000008, then trk_valid with cx=10, cy=20, w=3, h=4:
  - trk_wr_en pulses 8 times with matching trk_din.
  - res_valid a single cycle later with res_src=0 and fields 10/20/3/4.
- Both sources valid continuously for 3 frames, engine replying after each -> grant sequence 0,1,0; res_src sequence 0,1,0; src1_ready=0 throughout every src0 frame.
- trk_full toggled every other cycle during the frame -> exactly 8 transfers; no transfer in any trk_full=1 cycle; data order preserved.
- trk_valid asserted coincident with the 6th pixel -> after the 8th pixel, REPORT directly (no WAIT_RESULT cycle) with the captured values.
- With TRK_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no trk_valid after the frame -> res_valid at WAIT_RESULT entry+16 cycles with res_err=1 and fields 0; without the macro -> busy stays 1 and res_valid stays 0 for 1000 cycles.
